// File: rtl/fib_core.sv
// Fibonacci term generator with a programmable step rate, overflow restart,
// a sticky wrap flag and a snapshot port for atomic value/index readback.
module fib_core #(
  parameter int WIDTH      = 30,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  on,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  wrap_clr,
  input  logic                  snap_req,
  output logic [WIDTH-1:0]      value,
  output logic [7:0]            index,
  output logic                  step_valid,
  output logic                  wrapped,
  output logic [WIDTH-1:0]      snap_value,
  output logic [7:0]            snap_index,
  output logic                  snap_ack
);

  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic                  b_ovf;
  logic [PRESCALE_W-1:0] cnt;
  logic [WIDTH:0]        sum;
  logic                  tick;

  // >= rather than == so that lowering prescale mid-count fires at once.
  assign tick  = on && (cnt >= prescale);
  assign sum   = {1'b0, a} + {1'b0, b};
  assign value = a;

  // NOTE: non-blocking assignments let the snapshot capture the values held
  // before this edge's step, and let a later wrap-set override wrap_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a          <= '0;
      b          <= WIDTH'(1);
      b_ovf      <= 1'b0;
      index      <= '0;
      cnt        <= '0;
      wrapped    <= 1'b0;
      step_valid <= 1'b0;
      snap_value <= '0;
      snap_index <= '0;
      snap_ack   <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      snap_ack   <= snap_req;
      if (snap_req) begin
        snap_value <= a;
        snap_index <= index;
      end

      if (wrap_clr)
        wrapped <= 1'b0;

      if (clear) begin
        a     <= '0;
        b     <= WIDTH'(1);
        b_ovf <= 1'b0;
        index <= '0;
        cnt   <= '0;
      end else if (tick) begin
        cnt        <= '0;
        step_valid <= 1'b1;
        if (b_ovf) begin
          // The next term does not fit: restart the sequence.
          a       <= '0;
          b       <= WIDTH'(1);
          b_ovf   <= 1'b0;
          index   <= '0;
          wrapped <= 1'b1;
        end else begin
          a     <= b;
          b     <= sum[WIDTH-1:0];
          b_ovf <= sum[WIDTH];
          index <= index + 8'd1;
        end
      end else if (on) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/fib_core.md
# fib_core

Fibonacci sequence generator that feeds the Wishbone wrapper's `FIBONACCI_VAL` readback and the `io_out[37:8]` pads. It steps the sequence at a programmable rate while enabled and restarts cleanly when the sequence overflows `WIDTH` bits. A sticky wrap flag and a snapshot handshake let the bus side read a value and its index atomically.

## Interface
- `WIDTH`, default 30: value width in bits; legal range 8–64.
- `PRESCALE_W`, default 16: width of the prescale input.
- `clk` input 1: single clock (the wrapper drives it from `wb_clk_i`).
- `reset_n` input 1: asynchronous, active-low reset.
- `on` input 1: level; 1 runs the sequence, 0 freezes it.
- `clear` input 1: synchronous restart pulse.
- `prescale` input PRESCALE_W: one step every `prescale+1` enabled cycles.
- `wrap_clr` input 1: clears `wrapped`.
- `snap_req` input 1: one-cycle snapshot request.
- `value` output WIDTH: current term F(index).
- `index` output 8: current term number.
- `step_valid` output 1: one-cycle pulse, high in the cycle `value` and `index` first show a new term.
- `wrapped` output 1: sticky; set when the sequence restarts because of overflow.
- `snap_value` output WIDTH: captured `value`.
- `snap_index` output 8: captured `index`.
- `snap_ack` output 1: one-cycle pulse, high in the cycle the captured data is valid.

## Operation
- **Registers:**
  - `a` holds F(index) and drives `value`.
  - `b` holds F(index+1), WIDTH bits.
  - `b_ovf` is 1 if the true F(index+1) does not fit in WIDTH bits.
  - `cnt` is the prescale counter, PRESCALE_W bits.
- **Reset (`reset_n`=0, asynchronous):** a=0, b=1, b_ovf=0, index=0, cnt=0, wrapped=0, step_valid=0, snap_value=0, snap_index=0, snap_ack=0.
- **Tick:** `tick = on && (cnt >= prescale)`.
  - While `on`=1 and not tick: cnt increments.
  - On tick: cnt resets to 0.
  - While `on`=0: cnt holds.
  - Using `>=` means lowering `prescale` mid-count takes effect immediately.
- **Normal step** (tick and b_ovf=0): a<=b; b<=(a+b) truncated to WIDTH; b_ovf<=carry out of a+b; index<=index+1; step_valid<=1.
- **Wrap step** (tick and b_ovf=1): a<=0, b<=1, b_ovf<=0, index<=0, wrapped<=1, step_valid<=1.
- **`clear`:** same values as reset for a, b, b_ovf, index and cnt; step_valid<=0; `wrapped` is untouched. `clear` has priority over any tick in the same cycle.
- **`wrap_clr`:** clears `wrapped`. If a wrap step happens in the same cycle, set wins and `wrapped` stays 1.
- **`snap_req`:** at the next edge, snap_value<=a and snap_index<=index (pre-update values of that same edge), and snap_ack<=1 for one cycle. Back-to-back requests give back-to-back acks. snap outputs hold between requests.
- **index** never exceeds 93 for WIDTH ≤ 64, so 8 bits never wraps on its own.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- **Step latency:** if `on` rises before edge k with cnt already ≥ prescale, value updates at edge k. Otherwise steps occur every prescale+1 edges while `on` stays high.
- **prescale=0:** one step per cycle; step_valid stays high continuously.
- **Toggling `on`:** dropping `on` freezes a, b, index and cnt in place; resuming continues from the frozen cnt.
- **snap_ack:** one cycle after snap_req; `snap_value` is valid in the same cycle as snap_ack.
- **Reset mid-step:** asynchronous assert clears everything immediately. First activity is possible on the first edge after `reset_n` deasserts.
- **WIDTH=30 boundary:**
  - Index 44 is the last term: F44=701408733.
  - The step from index 43 sets b_ovf because F45=1134903170 ≥ 2^30.
  - The next step is a wrap step: value 0, index 0.

## Test plan
- **Reset values:** assert reset_n=0 asynchronously mid-run -> all outputs read 0 immediately, without waiting for a clock edge.
- **Full sequence at WIDTH=30:** prescale=0, on=1 -> after 10 steps value=55 and index=10; after 44 steps value=701408733; 45th step value=0, index=0, wrapped=1; next step value=1.
- **Prescale and freeze:** prescale=3 -> step_valid pulses every 4th cycle. Drop `on` for 5 cycles -> value, index and cnt frozen. Raise `on` -> the remaining count completes with no lost or extra step.
- **Clear priority:** clear and a tick in the same cycle, at index 20 with wrapped=1 -> value=0, index=0, step_valid=0, wrapped stays 1.
- **wrap_clr collision:** wrap_clr asserted in the same cycle as a wrap step -> wrapped=1. wrap_clr alone on a later cycle -> wrapped=0.
- **Snapshot during stepping:** snap_req pulsed while prescale=0 and value=13 (index 7) -> snap_ack one cycle later with snap_value=13 and snap_index=7, while value has already advanced to 21.
